// File: rtl/axi_stream_slave_monitor.sv
// axi_stream_slave_monitor
//   Receiver-side AXI4-Stream protocol checker with traffic statistics.
//   It sits passively on the stream feeding a slave DUT. Violations of the
//   master's rules and of the slave's stall bound raise sticky error flags.
//   Under FORMAL, the master rules become assumptions and the stall bound
//   becomes an assertion.
// Ports
//   clk, resetn        stream clock, async active-low reset
//   tvalid .. tuser    observed stream (tready is driven by the slave DUT)
//   beat_count         completed transfers (wraps)
//   packet_count       transfers carrying tlast (wraps)
//   byte_count         sum of popcount(tkeep) over transfers (wraps)
//   stall_count        current run of tvalid && !tready cycles (saturates)
//   in_packet          a non-last beat was accepted and the packet is still open
//   err_*              sticky violation flags; err_any is their OR

// Per-byte-lane strobe/keep consistency: a strobed byte must also be kept.
module axi_stream_slave_monitor_lane (
  input  logic strb,
  input  logic keep,
  output logic strb_bad
);
  assign strb_bad = strb & ~keep;
endmodule

module axi_stream_slave_monitor #(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_STALL  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    tvalid,
  input  logic                    tready,
  input  logic [8*byte_width-1:0] tdata,
  input  logic [byte_width-1:0]   tstrb,
  input  logic [byte_width-1:0]   tkeep,
  input  logic                    tlast,
  input  logic [id_width-1:0]     tid,
  input  logic [dest_width-1:0]   tdest,
  input  logic [user_width-1:0]   tuser,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    packet_count,
  output logic [CNT_WIDTH-1:0]    byte_count,
  output logic [15:0]             stall_count,
  output logic                    in_packet,
  output logic                    err_valid_drop,
  output logic                    err_unstable,
  output logic                    err_strb_keep,
  output logic                    err_reset_valid,
  output logic                    err_stall,
  output logic                    err_any
);

  localparam int PW = 10*byte_width + 1 + id_width + dest_width + user_width;
  localparam int KW = $clog2(byte_width + 1);

  // Whole beat payload, compared as one vector against the stalled snapshot.
  logic [PW-1:0] payload, snap;
  assign payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};

  logic pending;     // previous edge saw tvalid && !tready
  logic first_edge;  // armed by reset, consumed by the first edge after release

  logic xfer, stall;
  assign xfer  = tvalid & tready;
  assign stall = tvalid & ~tready;

  // Byte-lane strobe/keep checks
  logic [byte_width-1:0] strb_bad;
  for (genvar g = 0; g < byte_width; g++) begin : g_lane
    axi_stream_slave_monitor_lane u_lane (
      .strb     (tstrb[g]),
      .keep     (tkeep[g]),
      .strb_bad (strb_bad[g])
    );
  end

  logic [KW-1:0] keep_cnt;
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < byte_width; i++)
      keep_cnt = keep_cnt + KW'(tkeep[i]);
  end

  logic stall_hit;
  assign stall_hit = (MAX_STALL != 0) && stall && (stall_count == 16'(MAX_STALL));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_count      <= '0;
      packet_count    <= '0;
      byte_count      <= '0;
      stall_count     <= '0;
      in_packet       <= 1'b0;
      pending         <= 1'b0;
      snap            <= '0;
      first_edge      <= 1'b1;
      err_valid_drop  <= 1'b0;
      err_unstable    <= 1'b0;
      err_strb_keep   <= 1'b0;
      err_reset_valid <= 1'b0;
      err_stall       <= 1'b0;
    end else begin
      // Checks use pre-edge pending/snapshot/stall_count
      if (pending && !tvalid)                   err_valid_drop  <= 1'b1;
      if (pending && tvalid && payload != snap) err_unstable    <= 1'b1;
      if (tvalid && |strb_bad)                  err_strb_keep   <= 1'b1;
      if (first_edge && tvalid)                 err_reset_valid <= 1'b1;
      if (stall_hit)                            err_stall       <= 1'b1;
      first_edge <= 1'b0;

      pending <= stall;
      snap    <= payload;

      if (stall) begin
        if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      end else begin
        stall_count <= '0;
      end

      if (xfer) begin
        beat_count <= beat_count + 1'b1;
        byte_count <= byte_count + CNT_WIDTH'(keep_cnt);
        if (tlast) packet_count <= packet_count + 1'b1;
        in_packet <= ~tlast;
      end
    end
  end

  assign err_any = err_valid_drop | err_unstable | err_strb_keep |
                   err_reset_valid | err_stall;

`ifdef FORMAL
  logic past_valid;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) past_valid <= 1'b0;
    else         past_valid <= 1'b1;
  end

  always @(posedge clk) begin
    if (resetn && past_valid) begin
      if (pending)                       assume (tvalid);
      if (pending && tvalid)             assume (payload == snap);
      if (tvalid)                        assume (!(|strb_bad));
      if (first_edge)                    assume (!tvalid);
      if (MAX_STALL != 0)                assert (!stall_hit);
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_slave_monitor.sv
module tb_axi_stream_slave_monitor;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = '0, tkeep = '0;
  logic [0:0]  tid = '0, tdest = '0, tuser = '0;

  logic [31:0] beat_count, packet_count, byte_count;
  logic [15:0] stall_count;
  logic in_packet, err_valid_drop, err_unstable, err_strb_keep,
        err_reset_valid, err_stall, err_any;

  // Second monitor with the stall check disabled; only its stall flags are used
  logic [31:0] z_beat, z_pkt, z_bytes;
  logic [15:0] z_stall_count;
  logic z_inp, z_drop, z_unst, z_sk, z_rv, z_stall, z_any;

  always #5 clk = ~clk;

  axi_stream_slave_monitor #(.MAX_STALL(4)) u_dut (
    .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
    .tid(tid), .tdest(tdest), .tuser(tuser),
    .beat_count(beat_count), .packet_count(packet_count),
    .byte_count(byte_count), .stall_count(stall_count),
    .in_packet(in_packet), .err_valid_drop(err_valid_drop),
    .err_unstable(err_unstable), .err_strb_keep(err_strb_keep),
    .err_reset_valid(err_reset_valid), .err_stall(err_stall),
    .err_any(err_any)
  );

  axi_stream_slave_monitor #(.MAX_STALL(0)) u_nostall (
    .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
    .tid(tid), .tdest(tdest), .tuser(tuser),
    .beat_count(z_beat), .packet_count(z_pkt),
    .byte_count(z_bytes), .stall_count(z_stall_count),
    .in_packet(z_inp), .err_valid_drop(z_drop),
    .err_unstable(z_unst), .err_strb_keep(z_sk),
    .err_reset_valid(z_rv), .err_stall(z_stall),
    .err_any(z_any)
  );

  typedef struct packed {
    logic        v, r;
    logic [31:0] d;
    logic [3:0]  s, k;
    logic        l;
  } in_t;

  // err bits: {drop, unstable, strb_keep, reset_valid, stall, any}
  typedef struct packed {
    logic [31:0] beat, pkt, bytes;
    logic [15:0] stall;
    logic        inp;
    logic [5:0]  err;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_DROP = 6'b100001;
  localparam logic [5:0] E_UNST = 6'b010001;
  localparam logic [5:0] E_SK   = 6'b001001;
  localparam logic [5:0] E_RV   = 6'b000101;
  localparam logic [5:0] E_STL  = 6'b000011;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic in_t mk_in(logic v, logic r, logic [31:0] d,
                                logic [3:0] s, logic [3:0] k, logic l);
    in_t x;
    x.v = v; x.r = r; x.d = d; x.s = s; x.k = k; x.l = l;
    return x;
  endfunction

  function automatic exp_t mk_exp(int beat, int pkt, int bytes, int stall,
                                  logic inp, logic [5:0] err);
    exp_t x;
    x.beat = 32'(beat); x.pkt = 32'(pkt); x.bytes = 32'(bytes);
    x.stall = 16'(stall); x.inp = inp; x.err = err;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no expectation queued", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " beat"},  beat_count,   e.beat);
    chk({tag, " pkt"},   packet_count, e.pkt);
    chk({tag, " bytes"}, byte_count,   e.bytes);
    chk({tag, " stall"}, 32'(stall_count), 32'(e.stall));
    chk({tag, " inpkt"}, 32'(in_packet), 32'(e.inp));
    chk({tag, " err"}, 32'({err_valid_drop, err_unstable, err_strb_keep,
                             err_reset_valid, err_stall, err_any}), 32'(e.err));
  endtask

  // Drive at negedge, queue the expectation, sample 1 ns after the posedge
  task automatic cycle(in_t i, exp_t e, string tag);
    @(negedge clk);
    tvalid = i.v; tready = i.r; tdata = i.d;
    tstrb = i.s; tkeep = i.k; tlast = i.l;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic idle_inputs();
    tvalid = 0; tready = 0; tdata = '0; tstrb = '0; tkeep = '0; tlast = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  // Assert reset mid-cycle and verify the outputs clear without a clock edge
  task automatic async_reset_check(string tag);
    @(posedge clk);
    #2;
    resetn = 0;
    #1;
    sb.push_back(mk_exp(0, 0, 0, 0, 0, E_NONE));
    check_out(tag);
  endtask

  vec_t tbl[13];

  initial begin
    // Reset state
    #12;
    sb.push_back(mk_exp(0, 0, 0, 0, 0, E_NONE));
    check_out("reset");
    @(negedge clk);
    resetn = 1;

    // Packet of 4 full beats, a 3-cycle stall, then tkeep corner beats
    tbl[0]  = '{mk_in(0,0,32'h0,       4'h0,4'h0,0), mk_exp(0,0,0, 0,0,E_NONE)};
    tbl[1]  = '{mk_in(1,1,32'h11,      4'hF,4'hF,0), mk_exp(1,0,4, 0,1,E_NONE)};
    tbl[2]  = '{mk_in(1,1,32'h22,      4'hF,4'hF,0), mk_exp(2,0,8, 0,1,E_NONE)};
    tbl[3]  = '{mk_in(1,1,32'h33,      4'hF,4'hF,0), mk_exp(3,0,12,0,1,E_NONE)};
    tbl[4]  = '{mk_in(1,1,32'h44,      4'hF,4'hF,1), mk_exp(4,1,16,0,0,E_NONE)};
    tbl[5]  = '{mk_in(1,0,32'hA5A5A5A5,4'hF,4'hF,1), mk_exp(4,1,16,1,0,E_NONE)};
    tbl[6]  = '{mk_in(1,0,32'hA5A5A5A5,4'hF,4'hF,1), mk_exp(4,1,16,2,0,E_NONE)};
    tbl[7]  = '{mk_in(1,0,32'hA5A5A5A5,4'hF,4'hF,1), mk_exp(4,1,16,3,0,E_NONE)};
    tbl[8]  = '{mk_in(1,1,32'hA5A5A5A5,4'hF,4'hF,1), mk_exp(5,2,20,0,0,E_NONE)};
    tbl[9]  = '{mk_in(1,1,32'h55,      4'h0,4'h0,1), mk_exp(6,3,20,0,0,E_NONE)};
    tbl[10] = '{mk_in(1,1,32'h66,      4'h3,4'h3,0), mk_exp(7,3,22,0,1,E_NONE)};
    tbl[11] = '{mk_in(1,1,32'h77,      4'h8,4'h8,1), mk_exp(8,4,23,0,0,E_NONE)};
    tbl[12] = '{mk_in(0,0,32'h0,       4'h0,4'h0,0), mk_exp(8,4,23,0,0,E_NONE)};
    for (int n = 0; n < 13; n++) cycle(tbl[n].i, tbl[n].e, $sformatf("vec%0d", n));

    // Payload changes while stalled; flag is sticky until reset
    do_reset();
    cycle(mk_in(0,0,32'h0,4'h0,4'h0,0), mk_exp(0,0,0,0,0,E_NONE), "unst0");
    cycle(mk_in(1,0,32'h1,4'hF,4'hF,1), mk_exp(0,0,0,1,0,E_NONE), "unst1");
    cycle(mk_in(1,0,32'h2,4'hF,4'hF,1), mk_exp(0,0,0,2,0,E_UNST), "unst2");
    cycle(mk_in(1,1,32'h2,4'hF,4'hF,1), mk_exp(1,1,4,0,0,E_UNST), "unst3");
    cycle(mk_in(0,0,32'h0,4'h0,4'h0,0), mk_exp(1,1,4,0,0,E_UNST), "unst4");
    async_reset_check("unst_rst");

    // tvalid withdrawn while stalled
    do_reset();
    cycle(mk_in(0,0,32'h0,4'h0,4'h0,0), mk_exp(0,0,0,0,0,E_NONE), "drop0");
    cycle(mk_in(1,0,32'h7,4'hF,4'hF,0), mk_exp(0,0,0,1,0,E_NONE), "drop1");
    cycle(mk_in(0,0,32'h7,4'hF,4'hF,0), mk_exp(0,0,0,0,0,E_DROP), "drop2");

    // Strobe on a byte that is not kept
    do_reset();
    cycle(mk_in(0,0,32'h0,4'h0,4'h0,0), mk_exp(0,0,0,0,0,E_NONE), "sk0");
    cycle(mk_in(1,1,32'h9,4'h1,4'hE,1), mk_exp(1,1,3,0,0,E_SK),   "sk1");

    // Stall bound: MAX_STALL=4 fires on the 5th stall edge; MAX_STALL=0 never
    do_reset();
    cycle(mk_in(0,0,32'h0,4'h0,4'h0,0), mk_exp(0,0,0,0,0,E_NONE), "stl0");
    for (int k = 1; k <= 6; k++) begin
      cycle(mk_in(1,0,32'hBEEF,4'hF,4'hF,0),
            mk_exp(0,0,0,k,0,(k >= 5) ? E_STL : E_NONE), $sformatf("stl%0d", k));
      chk($sformatf("nostall%0d err_stall", k), 32'(z_stall), 32'(0));
      chk($sformatf("nostall%0d err_any", k),   32'(z_any),   32'(0));
      chk($sformatf("nostall%0d count", k),     32'(z_stall_count), 32'(k));
    end

    // Reset mid-packet, then tvalid high at the first edge after release
    do_reset();
    cycle(mk_in(0,0,32'h0,4'h0,4'h0,0), mk_exp(0,0,0,0,0,E_NONE), "mid0");
    cycle(mk_in(1,1,32'h1,4'hF,4'hF,0), mk_exp(1,0,4, 0,1,E_NONE), "mid1");
    cycle(mk_in(1,1,32'h2,4'hF,4'hF,0), mk_exp(2,0,8, 0,1,E_NONE), "mid2");
    cycle(mk_in(1,1,32'h3,4'hF,4'hF,0), mk_exp(3,0,12,0,1,E_NONE), "mid3");
    async_reset_check("mid_rst");
    tvalid = 1; tready = 1; tdata = 32'h4; tstrb = 4'hF; tkeep = 4'hF; tlast = 0;
    @(negedge clk);
    resetn = 1;
    sb.push_back(mk_exp(1,0,4,0,1,E_RV));
    @(posedge clk);
    #1;
    check_out("rv");
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
